cic_integrator_seq: RTL and testbench

- Upstream neighbour of the multichannel CIC comb stage in wb_mic_array.
- Takes one PDM bit per microphone per sample strobe and maps it to +1/-1.
- Keeps a per-channel integrator in a time-multiplexed accumulator memory.
- Every DECIMATION accepted samples, it drives the comb's read_en/wr_en/channel/data_in handshake once for every channel.

---
 rtl/cic_integrator_seq.sv | 135 +++++++++++++
 tb/tb_cic_integrator_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_integrator_seq.sv
// Time-multiplexed CIC integrator front end: maps PDM bits to +/-1, integrates per
// channel, and every DECIMATION accepted samples streams each channel to the comb.
module cic_integrator_seq #(
  parameter int WIDTH      = 22,
  parameter int CHANNELS   = 8,
  parameter int DECIMATION = 32,
  localparam int CH_W      = $clog2(CHANNELS),
  localparam int DEC_W     = $clog2(DECIMATION)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pdm_valid,
  input  logic [CHANNELS-1:0] pdm_data,
  input  logic                overrun_clr,
  output logic                busy,
  output logic                overrun,
  output logic                comb_read_en,
  output logic                comb_wr_en,
  output logic [CH_W-1:0]     comb_channel,
  output logic [WIDTH-1:0]    comb_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INTEG  = 2'd1,
    S_CREAD  = 2'd2,
    S_CWRITE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]  ONE_CH   = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [DEC_W-1:0] ONE_DEC  = {{(DEC_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [DEC_W-1:0] LAST_DEC = DEC_W'(DECIMATION - 1);

  state_t               state_r;
  logic [CH_W-1:0]      ch_idx_r;
  logic [DEC_W-1:0]     dec_count_r;
  logic [CHANNELS-1:0]  sample_r;
  logic [WIDTH-1:0]     acc_r [CHANNELS];

  // A PDM one counts as +1, a zero as -1; the sum wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] pdm_step(input logic [WIDTH-1:0] acc, input logic bit_in);
    if (bit_in) begin
      pdm_step = acc + ONE_W;
    end else begin
      pdm_step = acc - ONE_W;
    end
  endfunction

  // Sample acceptance, per-channel integration and the comb read/write sequence.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r      <= S_IDLE;
      ch_idx_r     <= {CH_W{1'b0}};
      dec_count_r  <= {DEC_W{1'b0}};
      sample_r     <= {CHANNELS{1'b0}};
      busy         <= 1'b0;
      comb_read_en <= 1'b0;
      comb_wr_en   <= 1'b0;
      comb_channel <= {CH_W{1'b0}};
      comb_data    <= {WIDTH{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      comb_read_en <= 1'b0;
      comb_wr_en   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pdm_valid) begin
            sample_r <= pdm_data;
            ch_idx_r <= {CH_W{1'b0}};
            busy     <= 1'b1;
            state_r  <= S_INTEG;
          end else begin
            state_r  <= S_IDLE;
          end
        end
        S_INTEG: begin
          acc_r[ch_idx_r] <= pdm_step(acc_r[ch_idx_r], sample_r[ch_idx_r]);
          if (ch_idx_r == LAST_CH) begin
            if (dec_count_r == LAST_DEC) begin
              dec_count_r <= {DEC_W{1'b0}};
              ch_idx_r    <= {CH_W{1'b0}};
              state_r     <= S_CREAD;
            end else begin
              dec_count_r <= dec_count_r + ONE_DEC;
              busy        <= 1'b0;
              state_r     <= S_IDLE;
            end
          end else begin
            ch_idx_r <= ch_idx_r + ONE_CH;
          end
        end
        S_CREAD: begin
          comb_read_en <= 1'b1;
          comb_channel <= ch_idx_r;
          state_r      <= S_CWRITE;
        end
        S_CWRITE: begin
          // Integration of this sample finished before the pass began, so acc is current.
          comb_wr_en   <= 1'b1;
          comb_channel <= ch_idx_r;
          comb_data    <= acc_r[ch_idx_r];
          if (ch_idx_r == LAST_CH) begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            ch_idx_r <= ch_idx_r + ONE_CH;
            state_r  <= S_CREAD;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new drop event takes priority over the clear.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      overrun <= 1'b0;
    end else if (pdm_valid && busy) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_cic_integrator_seq.sv
// Bench for cic_integrator_seq: a scheduled event model checked every cycle, plus
// literal expectations for the directed scenarios and a narrow-width wrap instance.
module tb_cic_integrator_seq;

  localparam int W = 8;
  localparam int C = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, pdm_valid, overrun_clr;
  logic [1:0] pdm_data;
  logic       busy, overrun, comb_read_en, comb_wr_en;
  logic [0:0] comb_channel;
  logic [7:0] comb_data;

  logic       w_resetn, w_valid, w_clr;
  logic [1:0] w_pdm;
  logic       w_busy, w_ovr, w_rd, w_wr;
  logic [0:0] w_ch;
  logic [3:0] w_data;

  cic_integrator_seq #(.WIDTH(W), .CHANNELS(C), .DECIMATION(D)) dut (
    .clk(clk), .resetn(resetn), .pdm_valid(pdm_valid), .pdm_data(pdm_data),
    .overrun_clr(overrun_clr), .busy(busy), .overrun(overrun),
    .comb_read_en(comb_read_en), .comb_wr_en(comb_wr_en),
    .comb_channel(comb_channel), .comb_data(comb_data)
  );

  cic_integrator_seq #(.WIDTH(4), .CHANNELS(2), .DECIMATION(9)) dut_wrap (
    .clk(clk), .resetn(w_resetn), .pdm_valid(w_valid), .pdm_data(w_pdm),
    .overrun_clr(w_clr), .busy(w_busy), .overrun(w_ovr),
    .comb_read_en(w_rd), .comb_wr_en(w_wr),
    .comb_channel(w_ch), .comb_data(w_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: sample sums per channel, plus the cycles at which each comb strobe must appear.
  int m_acc [C];
  int m_dec;
  int busy_start, busy_end;
  bit m_ovr;
  int rd_at [int];
  int wr_at [int];
  int wr_dat[int];
  int hold_ch, hold_data;
  bit prev_rd;
  int prev_ch;
  bit exp_busy, exp_rd, exp_wr;

  int wlog [C];
  int wr_count;
  int w_log [2];
  int w_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < C; i++) m_acc[i] = 0;
    m_dec = 0; busy_start = 0; busy_end = -1; m_ovr = 1'b0;
    rd_at.delete(); wr_at.delete(); wr_dat.delete();
    hold_ch = 0; hold_data = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // cyc is the index of the last rising edge; inputs seen here are taken at edge cyc+1.
  always @(negedge clk) begin
    if (resetn) model_reset();
    exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
    exp_rd   = rd_at.exists(cyc);
    exp_wr   = wr_at.exists(cyc);
    if (exp_rd) hold_ch = rd_at[cyc];
    if (exp_wr) begin
      hold_ch   = wr_at[cyc];
      hold_data = wr_dat[cyc];
    end
    chk("busy",    32'(busy),         32'(exp_busy));
    chk("overrun", 32'(overrun),      32'(m_ovr));
    chk("read_en", 32'(comb_read_en), 32'(exp_rd));
    chk("wr_en",   32'(comb_wr_en),   32'(exp_wr));
    chk("channel", 32'(comb_channel), 32'(hold_ch));
    chk("data",    32'(comb_data),    32'(hold_data & 255));
    chk("rd_wr_exclusive", 32'(comb_read_en && comb_wr_en), 32'd0);
    if (comb_wr_en === 1'b1) begin
      chk("wr_after_rd",    32'(prev_rd), 32'd1);
      chk("wr_rd_same_ch",  32'(prev_ch), 32'(comb_channel));
      wlog[comb_channel] = int'(comb_data);
      wr_count++;
    end
    if (w_wr === 1'b1) begin
      w_log[w_ch] = int'(w_data);
      w_count++;
    end
    if (!resetn) begin
      if (pdm_valid && exp_busy) begin
        m_ovr = 1'b1;
      end else begin
        if (overrun_clr) m_ovr = 1'b0;
        if (pdm_valid) begin
          for (int k = 0; k < C; k++) m_acc[k] += pdm_data[k] ? 1 : -1;
          busy_start = cyc + 1;
          if (m_dec == D - 1) begin
            m_dec = 0;
            busy_end = cyc + 3 * C;
            for (int k = 0; k < C; k++) begin
              rd_at[cyc + 1 + C + 1 + 2 * k]  = k;
              wr_at[cyc + 1 + C + 2 + 2 * k]  = k;
              wr_dat[cyc + 1 + C + 2 + 2 * k] = m_acc[k];
            end
          end else begin
            m_dec++;
            busy_end = cyc + C;
          end
        end
      end
    end
    prev_rd = comb_read_en;
    prev_ch = int'(comb_channel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] d, input int gap);
    pdm_valid = 1'b1;
    pdm_data  = d;
    tick();
    pdm_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
    tick();
    wr_count = 0;
  endtask

  initial begin
    bit found;
    pdm_valid = 1'b0; pdm_data = 2'b00; overrun_clr = 1'b0;
    w_valid = 1'b0; w_pdm = 2'b00; w_clr = 1'b0;
    wr_count = 0; w_count = 0;
    resetn = 1'b0; w_resetn = 1'b0;
    #1;
    resetn = 1'b1; w_resetn = 1'b1;
    repeat (3) tick();
    resetn = 1'b0; w_resetn = 1'b0;
    tick();

    // Narrow instance: nine +1/-1 steps wrap a 4-bit integrator.
    repeat (9) begin
      w_valid = 1'b1; w_pdm = 2'b01;
      tick();
      w_valid = 1'b0;
      repeat (5) tick();
    end
    repeat (10) tick();
    chk("wrap_writes", 32'(w_count), 32'd2);
    chk("wrap_ch0",    32'(w_log[0]), 32'd9);
    chk("wrap_ch1",    32'(w_log[1]), 32'd7);

    // All-ones: comb pass only on the fourth strobe.
    repeat (3) strobe(2'b11, 10);
    chk("no_pass_before_dec", 32'(wr_count), 32'd0);
    strobe(2'b11, 10);
    repeat (5) tick();
    chk("a_writes", 32'(wr_count), 32'd2);
    chk("a_ch0",    32'(wlog[0]), 32'd4);
    chk("a_ch1",    32'(wlog[1]), 32'd4);

    // Opposite signs, then back to zero on the next decimation.
    do_reset();
    repeat (4) strobe(2'b01, 10);
    repeat (5) tick();
    chk("b_writes", 32'(wr_count), 32'd2);
    chk("b_ch0",    32'(wlog[0]), 32'd4);
    chk("b_ch1",    32'(wlog[1]), 32'hFC);
    repeat (4) strobe(2'b10, 10);
    repeat (5) tick();
    chk("b2_writes", 32'(wr_count), 32'd4);
    chk("b2_ch0",    32'(wlog[0]), 32'd0);
    chk("b2_ch1",    32'(wlog[1]), 32'd0);

    // Back-to-back strobe and strobe in the busy-falling cycle are both dropped.
    do_reset();
    pdm_valid = 1'b1; pdm_data = 2'b11;
    tick();
    pdm_data = 2'b00;
    tick();
    pdm_valid = 1'b0;
    chk("ovr_set", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);
    repeat (5) tick();
    pdm_valid = 1'b1; pdm_data = 2'b01;
    tick();
    pdm_valid = 1'b0;
    tick();
    pdm_valid = 1'b1; pdm_data = 2'b00;
    tick();
    pdm_valid = 1'b0;
    chk("ovr_busy_fall", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    repeat (8) tick();
    chk("c_no_early_pass", 32'(wr_count), 32'd0);
    repeat (2) strobe(2'b01, 10);
    repeat (5) tick();
    chk("c_writes", 32'(wr_count), 32'd2);
    chk("c_ch0",    32'(wlog[0]), 32'd4);
    chk("c_ch1",    32'(wlog[1]), 32'hFE);

    // Reset while the ch0 write is being issued.
    do_reset();
    repeat (3) strobe(2'b11, 10);
    pdm_valid = 1'b1; pdm_data = 2'b11;
    tick();
    pdm_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (comb_read_en === 1'b1 && comb_channel === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("d_read_ch0_seen", 32'(found), 32'd1);
    resetn = 1'b1;
    #1;
    chk("d_rst_busy",    32'(busy),         32'd0);
    chk("d_rst_overrun", 32'(overrun),      32'd0);
    chk("d_rst_read",    32'(comb_read_en), 32'd0);
    chk("d_rst_write",   32'(comb_wr_en),   32'd0);
    chk("d_rst_channel", 32'(comb_channel), 32'd0);
    chk("d_rst_data",    32'(comb_data),    32'd0);
    tick();
    resetn = 1'b0;
    tick();
    wr_count = 0;
    repeat (20) tick();
    chk("d_no_strobes_after_rst", 32'(wr_count), 32'd0);
    repeat (4) strobe(2'b11, 10);
    repeat (5) tick();
    chk("d_writes", 32'(wr_count), 32'd2);
    chk("d_ch0",    32'(wlog[0]), 32'd4);
    chk("d_ch1",    32'(wlog[1]), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
